bus_reader: RTL

BUS_READER -- requirements
Module: bus_reader

---
 rtl/bus_reader.sv | 94 +++++++++
 1 files changed

// File: rtl/bus_reader.sv
// Single-register read port for an 8x8 register bank: select, capture (with
// write forwarding), then hold the result until the consumer acknowledges.
module bus_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] addr,
  input  logic       ack,
  output logic       rdy,
  output logic       valid,
  output logic [7:0] data_out,
  output logic [2:0] bus_sel,
  output logic       bus_en,
  input  logic [7:0] bus_data,
  input  logic       wr_load,
  input  logic [2:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    CAPTURE = 2'd2,
    VALID   = 2'd3
  } state_t;

  // Handshake: a request is taken on an edge where req=1 and rdy=1; a result
  // is handed over on an edge where valid=1 and ack=1. Nothing is queued.

  state_t     state, state_nxt;
  logic [2:0] addr_q;
  logic       accept;
  logic       capture;
  logic       done;
  logic [7:0] capture_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= 3'd0;
      data_out <= 8'h00;
      rd_count <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept)  addr_q   <= addr;
      if (capture) data_out <= capture_data;
      if (done)    rd_count <= rd_count + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = SELECT;
        end
      end
      SELECT:  state_nxt = CAPTURE;
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = VALID;
      end
      VALID: begin
        if (ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A write to the register being read lands in the bank on this same edge,
  // so the bank output is stale; take the write data instead.
  always_comb begin
    capture_data = bus_data;
    if (wr_load && (wr_sel == addr_q)) capture_data = wr_data;
  end

  // addr_q only changes on accept, so bus_sel holds between reads.
  assign bus_sel   = addr_q;
  assign bus_en    = (state == SELECT) || (state == CAPTURE);
  assign rdy       = (state == IDLE);
  assign valid     = (state == VALID);
  assign state_dbg = state;

endmodule
